perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of hardware event counters: successor to the per-signal `PERF` macro counter, for profiling the core in both synthesis and DIFFTEST builds. Counts NUM_EVENTS independent event streams with multi-unit increments, per-channel wrap or saturate mode, sticky overflow, and atomic snapshot into shadow registers. A valid/ready read port returns shadow values. Instantiated once per subsystem (frontend, backend, LSU) and read by the debug/CSR logic.

## Interface
Parameters:
- NUM_EVENTS, 16: number of counter channels (≥1)
- CNT_WIDTH, 48: counter width in bits
- INC_WIDTH, 3: per-cycle increment width per channel (max increment 2^INC_WIDTH-1)
- DUMP_INTERVAL, 0: cycles between automatic snapshots; 0 disables
- IDX_WIDTH, $clog2(NUM_EVENTS) (min 1): read index width

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high (`RST`)
- en  in  1  global count enable
- clear  in  1  synchronous clear of counters and overflow flags
- event_inc  in  NUM_EVENTS×INC_WIDTH  per-channel increment this cycle
- sat_mode  in  NUM_EVENTS  1 = saturate, 0 = wrap
- snap_req  in  1  snapshot request (single-cycle pulse semantics)
- snap_done  out  1  pulse: shadow registers updated at this edge
- ovf  out  NUM_EVENTS  live sticky overflow flags
- rd_req_valid  in  1  read request
- rd_req_ready  out  1  read request accepted
- rd_idx  in  IDX_WIDTH  channel to read
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  CNT_WIDTH  shadow counter value
- rsp_ovf  out  1  shadow overflow flag
- rsp_err  out  1  rd_idx ≥ NUM_EVENTS

## Operation
- Reset: all counters, shadows, ovf, interval counter = 0; snap_done, rsp_valid, rsp_data, rsp_ovf, rsp_err = 0.
- Per channel i, cnt_next = cnt + (en ? event_inc[i] : 0), computed CNT_WIDTH+1 wide.
  - Carry out, wrap mode: keep low CNT_WIDTH bits, set ovf[i].
  - Carry out, saturate mode: hold 2^CNT_WIDTH-1, set ovf[i]; stays there until clear.
- ovf[i] sticky; cleared only by clear or rst.
- Snapshot trigger = snap_req OR interval expiry. On trigger: shadow_cnt[i] <= cnt_next[i], shadow_ovf[i] <= ovf_next[i] (includes this cycle's increment and overflow, ignores same-cycle clear).
- clear: cnt and ovf <= 0; increments that cycle discarded from the counters. clear+trigger in the same cycle = read-and-reset: shadow receives pre-clear cnt_next, counters go to 0.
- Interval counter (DUMP_INTERVAL>0): counts every cycle regardless of en; triggers when it reaches DUMP_INTERVAL-1, then returns to 0; reset to 0 by clear.
- Read port: reads shadow only, never live counters.
  - rd_req_ready = !rsp_valid || rsp_ready.
  - On accept: rsp registers load shadow[rd_idx] (value before any same-edge snapshot); rsp_valid <= 1.
  - rd_idx ≥ NUM_EVENTS: rsp_data=0, rsp_ovf=0, rsp_err=1.
  - rsp_valid && !rsp_ready: all rsp_* held stable.
  - rsp_ready with no new accept: rsp_valid <= 0.
- Reset mid-read: response dropped, rsp_valid=0 immediately (async).

## Timing
- Event at cycle N visible in cnt at N+1 and in shadow at N+1 if trigger at N.
- snap_done asserted in cycle N+1 for a trigger at cycle N; back-to-back triggers give back-to-back pulses.
- Read latency 1 cycle: accept at N → rsp_valid at N+1. Full throughput: one response per cycle with rsp_ready held high.
- No combinational path from rsp_ready to rsp_data; rd_req_ready is the only combinational output (from rsp_ready).

## Structure
- Package `perf_pkg`: typedef of the per-channel increment vector and a `PERF_SAT`/`PERF_WRAP` mode constant pair.
- Sub-module `perf_counter_cell`: one counter + ovf + shadow, with the wrap/saturate logic; bank generates NUM_EVENTS instances plus interval counter and read port.

## Test plan
- CNT_WIDTH=8, wrap, inc=3 each cycle from 250 → cnt 253, then 0 (256 mod 256), ovf[i]=1 and stays 1.
- CNT_WIDTH=8, saturate, cnt=254, inc=7 → cnt 255, ovf=1; further incs hold 255; clear → 0, ovf 0.
- cnt=100, inc=5, snap_req and clear same cycle → shadow=105, cnt=0 next cycle, snap_done pulse one cycle later.
- DUMP_INTERVAL=10, no snap_req → snap_done every 10 cycles; clear at cycle 4 restarts interval.
- Read idx 2 with rsp_ready low 3 cycles → rsp_data stable, rd_req_ready=0; idx=NUM_EVENTS → rsp_err=1, data 0.
- Async rst asserted while rsp_valid=1 → all outputs 0 before next edge.

Source files
------------

// File: rtl/perf_counter_bank_pkg.sv
// perf_pkg: shared types and constants for the performance counter bank.
//   perf_mode_e  - per-channel overflow behaviour (PERF_WRAP / PERF_SAT)
//   perf_inc_t   - per-channel increment at the default increment width
//   perf_idx_width() - read index width for a given channel count (min 1)
package perf_pkg;

   typedef enum logic {
      PERF_WRAP = 1'b0,
      PERF_SAT  = 1'b1
   } perf_mode_e;

   localparam int PERF_INC_WIDTH_DEFAULT = 3;

   typedef logic [PERF_INC_WIDTH_DEFAULT-1:0] perf_inc_t;

   function automatic int perf_idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: one event counter with sticky overflow and a shadow copy.
// Ports:
//   clk, rst          clock, async active-high reset
//   en_i              global count enable
//   clear_i           synchronous clear of counter and overflow flag
//   inc_i             increment for this cycle
//   sat_mode_i        1 = saturate at all-ones, 0 = wrap
//   snap_i            copy next counter/overflow state into the shadow
//   ovf_o             live sticky overflow flag
//   shadow_cnt_o      shadow counter value
//   shadow_ovf_o      shadow overflow flag
module perf_counter_cell
   import perf_pkg::*;
#(
   parameter int CNT_WIDTH = 48,
   parameter int INC_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic                 clear_i,
   input  logic [INC_WIDTH-1:0] inc_i,
   input  logic                 sat_mode_i,
   input  logic                 snap_i,
   output logic                 ovf_o,
   output logic [CNT_WIDTH-1:0] shadow_cnt_o,
   output logic                 shadow_ovf_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_next;
   logic                 ovf_q, ovf_d, ovf_next;
   logic [CNT_WIDTH-1:0] shadow_cnt_q, shadow_cnt_d;
   logic                 shadow_ovf_q, shadow_ovf_d;
   logic [CNT_WIDTH:0]   sum;
   logic                 carry;
   perf_mode_e           mode;

   assign mode  = perf_mode_e'(sat_mode_i);
   // One extra bit catches the carry out of the counter.
   assign sum   = {1'b0, cnt_q} + (CNT_WIDTH+1)'(en_i ? inc_i : '0);
   assign carry = sum[CNT_WIDTH];

   always_comb begin
      cnt_next = sum[CNT_WIDTH-1:0];
      if (carry && (mode == PERF_SAT)) cnt_next = '1;
      ovf_next = ovf_q | carry;
   end

   // Shadow captures the pre-clear next state so clear+snap acts as read-and-reset.
   always_comb begin
      cnt_d        = clear_i ? '0 : cnt_next;
      ovf_d        = clear_i ? 1'b0 : ovf_next;
      shadow_cnt_d = snap_i ? cnt_next : shadow_cnt_q;
      shadow_ovf_d = snap_i ? ovf_next : shadow_ovf_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         shadow_cnt_q <= '0;
         shadow_ovf_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         shadow_cnt_q <= shadow_cnt_d;
         shadow_ovf_q <= shadow_ovf_d;
      end
   end

   assign ovf_o        = ovf_q;
   assign shadow_cnt_o = shadow_cnt_q;
   assign shadow_ovf_o = shadow_ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_EVENTS event counters with wrap/saturate mode, sticky
// overflow, atomic snapshot into shadow registers (on request or on a periodic
// interval) and a valid/ready read port returning shadow values.
// Ports:
//   clk, rst                  clock, async active-high reset
//   en, clear                 global count enable, synchronous clear
//   event_inc, sat_mode       per-channel increment and overflow mode
//   snap_req / snap_done      snapshot request pulse / shadow-updated pulse
//   ovf                       live sticky overflow flags
//   rd_req_valid/ready, rd_idx       read request channel
//   rsp_valid/ready, rsp_data/ovf/err read response channel
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_EVENTS    = 16,
   parameter int CNT_WIDTH     = 48,
   parameter int INC_WIDTH     = 3,
   parameter int DUMP_INTERVAL = 0,
   parameter int IDX_WIDTH     = perf_idx_width(NUM_EVENTS)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 en,
   input  logic                                 clear,
   input  logic [NUM_EVENTS-1:0][INC_WIDTH-1:0] event_inc,
   input  logic [NUM_EVENTS-1:0]                sat_mode,
   input  logic                                 snap_req,
   output logic                                 snap_done,
   output logic [NUM_EVENTS-1:0]                ovf,
   input  logic                                 rd_req_valid,
   output logic                                 rd_req_ready,
   input  logic [IDX_WIDTH-1:0]                 rd_idx,
   output logic                                 rsp_valid,
   input  logic                                 rsp_ready,
   output logic [CNT_WIDTH-1:0]                 rsp_data,
   output logic                                 rsp_ovf,
   output logic                                 rsp_err
);

   logic                                 snap_trig;
   logic                                 ival_trig;
   logic                                 snap_done_q;
   logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] shadow_cnt;
   logic [NUM_EVENTS-1:0]                shadow_ovf;

   assign snap_trig = snap_req | ival_trig;

   // ---------------- counter cells ----------------
   for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cell
      perf_counter_cell #(
         .CNT_WIDTH (CNT_WIDTH),
         .INC_WIDTH (INC_WIDTH)
      ) u_cell (
         .clk          (clk),
         .rst          (rst),
         .en_i         (en),
         .clear_i      (clear),
         .inc_i        (event_inc[i]),
         .sat_mode_i   (sat_mode[i]),
         .snap_i       (snap_trig),
         .ovf_o        (ovf[i]),
         .shadow_cnt_o (shadow_cnt[i]),
         .shadow_ovf_o (shadow_ovf[i])
      );
   end

   // ---------------- periodic snapshot ----------------
   if (DUMP_INTERVAL > 0) begin : g_ival
      localparam int IVW = $clog2(DUMP_INTERVAL + 1);
      logic [IVW-1:0] ival_q, ival_d;
      logic           hit;

      // Free-running regardless of en; clear restarts the period.
      assign hit = (ival_q == IVW'(DUMP_INTERVAL - 1));

      always_comb begin
         ival_d = ival_q + IVW'(1);
         if (clear || hit) ival_d = '0;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) ival_q <= '0;
         else     ival_q <= ival_d;
      end

      assign ival_trig = hit;
   end else begin : g_no_ival
      assign ival_trig = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) snap_done_q <= 1'b0;
      else     snap_done_q <= snap_trig;
   end

   assign snap_done = snap_done_q;

   // ---------------- read port ----------------
   logic                 rsp_valid_q, rsp_valid_d;
   logic [CNT_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                 rsp_ovf_q, rsp_ovf_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [CNT_WIDTH-1:0] sel_cnt;
   logic                 sel_ovf;
   logic                 idx_ok;
   logic                 accept;

   assign rd_req_ready = !rsp_valid_q || rsp_ready;
   assign accept       = rd_req_valid && rd_req_ready;
   assign idx_ok       = ({1'b0, rd_idx} < (IDX_WIDTH+1)'(NUM_EVENTS));

   // Decoded mux: an out-of-range index selects nothing and yields zeros.
   always_comb begin
      sel_cnt = '0;
      sel_ovf = 1'b0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (rd_idx == IDX_WIDTH'(i)) begin
            sel_cnt = shadow_cnt[i];
            sel_ovf = shadow_ovf[i];
         end
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_ovf_d   = rsp_ovf_q;
      rsp_err_d   = rsp_err_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = sel_cnt;
         rsp_ovf_d   = sel_ovf;
         rsp_err_d   = !idx_ok;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_ovf_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_ovf_q   <= rsp_ovf_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
   localparam int NE   = 5;
   localparam int CW   = 8;
   localparam int IW   = 3;
   localparam int DI   = 10;
   localparam int IDXW = 3;
   localparam int MAXV = (1 << CW) - 1;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   en = 1'b1;
   logic                   clear = 1'b0;
   logic [NE-1:0][IW-1:0]  event_inc = '0;
   logic [NE-1:0]          sat_mode = '0;
   logic                   snap_req = 1'b0;
   logic                   snap_done;
   logic [NE-1:0]          ovf;
   logic                   rd_req_valid = 1'b0;
   logic                   rd_req_ready;
   logic [IDXW-1:0]        rd_idx = '0;
   logic                   rsp_valid;
   logic                   rsp_ready = 1'b1;
   logic [CW-1:0]          rsp_data;
   logic                   rsp_ovf;
   logic                   rsp_err;

   int total = 0;
   int bad   = 0;

   perf_counter_bank #(
      .NUM_EVENTS(NE), .CNT_WIDTH(CW), .INC_WIDTH(IW),
      .DUMP_INTERVAL(DI), .IDX_WIDTH(IDXW)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .event_inc(event_inc),
      .sat_mode(sat_mode), .snap_req(snap_req), .snap_done(snap_done), .ovf(ovf),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_idx(rd_idx),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_cnt [NE];
   bit m_ovf [NE];
   int m_sh  [NE];
   bit m_sho [NE];
   int m_since;      // cycles since reset or last clear
   bit m_snap;
   bit m_rv;
   int m_rd;
   bit m_ro, m_re;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NE; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_sh[i] = 0; m_sho[i] = 0;
         end
         m_since = 0; m_snap = 0; m_rv = 0; m_rd = 0; m_ro = 0; m_re = 0;
      end else begin
         bit trig;
         // read port sees shadows as they were before this edge
         if (rd_req_valid && (!m_rv || rsp_ready)) begin
            m_rv = 1;
            if (int'(rd_idx) < NE) begin
               m_rd = m_sh[rd_idx]; m_ro = m_sho[rd_idx]; m_re = 0;
            end else begin
               m_rd = 0; m_ro = 0; m_re = 1;
            end
         end else if (rsp_ready) begin
            m_rv = 0;
         end
         trig = snap_req || ((m_since % DI) == DI - 1);
         m_since = clear ? 0 : m_since + 1;
         for (int i = 0; i < NE; i++) begin
            int s;
            bit o;
            s = m_cnt[i] + (en ? int'(event_inc[i]) : 0);
            o = m_ovf[i];
            if (s > MAXV) begin
               o = 1;
               s = sat_mode[i] ? MAXV : s - (MAXV + 1);
            end
            if (trig) begin m_sh[i] = s; m_sho[i] = o; end
            if (clear) begin m_cnt[i] = 0; m_ovf[i] = 0; end
            else begin m_cnt[i] = s; m_ovf[i] = o; end
         end
         m_snap = trig;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            logic [NE-1:0] eo;
            for (int i = 0; i < NE; i++) eo[i] = m_ovf[i];
            chk("ovf", 64'(ovf), 64'(eo));
            chk("snap_done", 64'(snap_done), 64'(m_snap));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
            chk("rd_req_ready", 64'(rd_req_ready), 64'(!m_rv || rsp_ready));
            if (m_rv) begin
               chk("rsp_data", 64'(rsp_data), 64'(m_rd));
               chk("rsp_ovf", 64'(rsp_ovf), 64'(m_ro));
               chk("rsp_err", 64'(rsp_err), 64'(m_re));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic [NE-1:0][IW-1:0] inc, input logic snp, input logic clr);
      event_inc = inc; snap_req = snp; clear = clr;
      @(negedge clk); #1;
      event_inc = '0; snap_req = 1'b0; clear = 1'b0;
   endtask

   task automatic pump(input int ch, input int amount);
      logic [NE-1:0][IW-1:0] v;
      int t;
      int a;
      t = amount;
      while (t > 0) begin
         a = (t > 7) ? 7 : t;
         v = '0;
         v[ch] = IW'(a);
         cyc(v, 1'b0, 1'b0);
         t -= a;
      end
   endtask

   task automatic one(input int ch, input int a, input logic snp, input logic clr);
      logic [NE-1:0][IW-1:0] v;
      v = '0;
      v[ch] = IW'(a);
      cyc(v, snp, clr);
   endtask

   task automatic rd(input int idx, input int ed, input logic eo, input logic ee);
      rd_req_valid = 1'b1; rd_idx = IDXW'(idx); rsp_ready = 1'b1;
      @(negedge clk); #1;
      rd_req_valid = 1'b0;
      chk("rd.valid", 64'(rsp_valid), 64'd1);
      chk("rd.data", 64'(rsp_data), 64'(ed));
      chk("rd.ovf", 64'(rsp_ovf), 64'(eo));
      chk("rd.err", 64'(rsp_err), 64'(ee));
      @(negedge clk); #1;
   endtask

   task automatic wait_pulse(output int k);
      k = 0;
      do begin
         cyc('0, 1'b0, 1'b0);
         k++;
      end while (!snap_done && k < 40);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      // reset state
      repeat (2) @(negedge clk);
      chk("rst.snap_done", 64'(snap_done), 64'd0);
      chk("rst.ovf", 64'(ovf), 64'd0);
      chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst.rsp_data", 64'(rsp_data), 64'd0);
      chk("rst.rsp_err", 64'(rsp_err), 64'd0);
      #1 rst = 1'b0;
      @(negedge clk); #1;

      // wrap: 250 + 3 -> 253, + 3 -> 0 with overflow
      cyc('0, 1'b0, 1'b1);
      pump(0, 250);
      one(0, 3, 1'b1, 1'b0);
      rd(0, 253, 1'b0, 1'b0);
      one(0, 3, 1'b1, 1'b0);
      rd(0, 0, 1'b1, 1'b0);
      repeat (3) cyc('0, 1'b0, 1'b0);
      chk("wrap.ovf_sticky", 64'(ovf[0]), 64'd1);

      // saturate: 254 + 7 -> 255, holds; clear -> 0
      sat_mode[1] = 1'b1;
      pump(1, 254);
      one(1, 7, 1'b1, 1'b0);
      rd(1, 255, 1'b1, 1'b0);
      one(1, 7, 1'b0, 1'b0);
      one(1, 7, 1'b1, 1'b0);
      rd(1, 255, 1'b1, 1'b0);
      cyc('0, 1'b0, 1'b1);
      chk("sat.clear_ovf", 64'(ovf[1]), 64'd0);
      cyc('0, 1'b1, 1'b0);
      rd(1, 0, 1'b0, 1'b0);

      // read-and-reset: 100 + 5 with snap+clear
      pump(2, 100);
      one(2, 5, 1'b1, 1'b1);
      chk("rr.snap_done", 64'(snap_done), 64'd1);
      rd(2, 105, 1'b0, 1'b0);
      cyc('0, 1'b1, 1'b0);
      rd(2, 0, 1'b0, 1'b0);

      // periodic snapshot every DI cycles, clear restarts the period
      cyc('0, 1'b0, 1'b1);
      wait_pulse(k); chk("ival.first", 64'(k), 64'd10);
      wait_pulse(k); chk("ival.period", 64'(k), 64'd10);
      repeat (3) cyc('0, 1'b0, 1'b0);
      cyc('0, 1'b0, 1'b1);
      wait_pulse(k); chk("ival.restart", 64'(k), 64'd10);

      // backpressure: idx 2 held while rsp_ready low
      pump(2, 37);
      cyc('0, 1'b1, 1'b0);
      rd_req_valid = 1'b1; rd_idx = 3'd2; rsp_ready = 1'b0;
      @(negedge clk); #1;
      chk("bp.valid", 64'(rsp_valid), 64'd1);
      chk("bp.data", 64'(rsp_data), 64'd37);
      rd_idx = 3'd3;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk("bp.ready_low", 64'(rd_req_ready), 64'd0);
         chk("bp.data_hold", 64'(rsp_data), 64'd37);
      end
      rd_idx = 3'd5; rsp_ready = 1'b1;
      #1 chk("bp.ready_comb", 64'(rd_req_ready), 64'd1);
      @(negedge clk); #1;
      rd_req_valid = 1'b0;
      chk("err.err", 64'(rsp_err), 64'd1);
      chk("err.data", 64'(rsp_data), 64'd0);
      chk("err.ovf", 64'(rsp_ovf), 64'd0);
      @(negedge clk); #1;

      // async reset while a response is pending
      pump(3, 260);
      chk("rst2.ovf_pre", 64'(ovf[3]), 64'd1);
      rd_req_valid = 1'b1; rd_idx = 3'd3; rsp_ready = 1'b0;
      @(negedge clk); #1;
      rd_req_valid = 1'b0;
      chk("rst2.valid_pre", 64'(rsp_valid), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst2.rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst2.rsp_data", 64'(rsp_data), 64'd0);
      chk("rst2.rsp_ovf", 64'(rsp_ovf), 64'd0);
      chk("rst2.ovf", 64'(ovf), 64'd0);
      chk("rst2.snap_done", 64'(snap_done), 64'd0);
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;

      // randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         if (c % 200 == 0) sat_mode = NE'($urandom);
         for (int i = 0; i < NE; i++) event_inc[i] = IW'($urandom_range(0, 7));
         en           = ($urandom_range(0, 3) != 0);
         snap_req     = ($urandom_range(0, 7) == 0);
         clear        = ($urandom_range(0, 39) == 0);
         rd_req_valid = $urandom_range(0, 1) == 1;
         rd_idx       = IDXW'($urandom_range(0, 7));
         rsp_ready    = ($urandom_range(0, 2) != 0);
         @(negedge clk); #1;
      end
      event_inc = '0; snap_req = 1'b0; clear = 1'b0; rd_req_valid = 1'b0;
      @(negedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
